// File: rtl/dnn_sdram_responder.sv
// rtl/dnn_sdram_responder.sv - Avalon-MM pipelined-read SDRAM stand-in with stall, fixed latency and backdoor
//
// Word-addressed 32-bit memory answering the DNN master's SDRAM port.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   slave_*              Avalon-MM slave: address (byte), read, write, writedata,
//                        waitrequest, readdata, readdatavalid
//   stall_cycles         waitrequest cycles imposed on each new request
//   bd_addr/we/wdata     backdoor write port (word index)
//   bd_rdata             backdoor read data, one cycle after bd_addr
//   err_oor, err_proto   sticky out-of-range / read+write-together flags
//   rd_count, wr_count   accepted read / write counters (wrapping)
module dnn_sdram_responder #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned READ_LAT = 2,
  parameter logic [31:0] OOR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  output logic              slave_waitrequest,
  output logic [31:0]       slave_readdata,
  output logic              slave_readdatavalid,
  input  logic [3:0]        stall_cycles,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic              bd_we,
  input  logic [31:0]       bd_wdata,
  output logic [31:0]       bd_rdata,
  output logic              err_oor,
  output logic              err_proto,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_IDLE, ST_STALL} state_e;

  state_e            state_q, state_d;
  logic [3:0]        sc_q, sc_d;
  logic [3:0]        sc_eff;
  logic              ready_q;
  logic              req, both, accept, rd_acc, wr_acc;
  logic [ADDR_W-1:0] widx;
  logic              oor;
  logic [31:0]       rd_word;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       bd_rdata_q;
  logic [READ_LAT-1:0] vld_q;
  logic [31:0]       dat_q [READ_LAT];
  logic [READ_LAT-1:0] stage_vld_in;
  logic [31:0]       stage_dat_in [READ_LAT];
  logic              err_oor_q, err_proto_q;
  logic [15:0]       rd_count_q, wr_count_q;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^slave_address[1:0];

  assign widx = slave_address[ADDR_W+1:2];
  assign oor  = |slave_address[31:ADDR_W+2];
  assign both = slave_read & slave_write;
  assign req  = slave_read ^ slave_write;

  // A fresh request sees a stall count of zero in its first cycle.
  assign sc_eff = (state_q == ST_STALL) ? sc_q : 4'd0;

  always_comb begin
    state_d           = ST_IDLE;
    sc_d              = 4'd0;
    accept            = ready_q && req && (sc_eff >= stall_cycles);
    slave_waitrequest = !ready_q || both || (req && (sc_eff < stall_cycles));
    // Stay in the stall state only while a request keeps being held off;
    // a dropped request falls back to idle with no side effects.
    if (ready_q && req && !accept) begin
      state_d = ST_STALL;
      sc_d    = sc_eff + 4'd1;
    end
  end

  assign rd_acc = accept & slave_read;
  assign wr_acc = accept & slave_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sc_q    <= 4'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      ready_q <= 1'b1;
    end
  end

  // Memory has no reset. The slave write is placed last so it wins a
  // same-word collision with the backdoor.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem_q[bd_addr] <= bd_wdata;
    end
    if (rst_n && wr_acc && !oor) begin
      mem_q[widx] <= slave_writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bd_rdata_q <= 32'd0;
    end else begin
      bd_rdata_q <= mem_q[bd_addr];
    end
  end

  assign rd_word = oor ? OOR_DATA : mem_q[widx];

  // Read pipeline: stage 0 captures at accept, the last stage drives the bus.
  // Data only moves alongside its valid bit, so the last stage holds readdata.
  always_comb begin
    stage_vld_in[0] = rd_acc;
    stage_dat_in[0] = rd_word;
    for (int i = 1; i < int'(READ_LAT); i++) begin
      stage_vld_in[i] = vld_q[i-1];
      stage_dat_in[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(READ_LAT); i++) begin
        dat_q[i] <= 32'd0;
      end
    end else begin
      vld_q <= stage_vld_in;
      for (int i = 0; i < int'(READ_LAT); i++) begin
        if (stage_vld_in[i]) begin
          dat_q[i] <= stage_dat_in[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count_q  <= 16'd0;
      wr_count_q  <= 16'd0;
      err_oor_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      if (rd_acc) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
      if (wr_acc) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
      if (accept && oor) begin
        err_oor_q <= 1'b1;
      end
      if (both) begin
        err_proto_q <= 1'b1;
      end
    end
  end

  assign slave_readdatavalid = vld_q[READ_LAT-1];
  assign slave_readdata      = dat_q[READ_LAT-1];
  assign bd_rdata            = bd_rdata_q;
  assign err_oor             = err_oor_q;
  assign err_proto           = err_proto_q;
  assign rd_count            = rd_count_q;
  assign wr_count            = wr_count_q;

endmodule

// File: tb/tb_dnn_sdram_responder.sv
// tb/tb_dnn_sdram_responder.sv - self-checking bench for dnn_sdram_responder
module tb_dnn_sdram_responder;

  localparam int          ADDR_W   = 10;
  localparam int          READ_LAT = 2;
  localparam logic [31:0] OOR      = 32'hDEADBEEF;
  localparam int          DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       slave_address;
  logic              slave_read;
  logic              slave_write;
  logic [31:0]       slave_writedata;
  logic              slave_waitrequest;
  logic [31:0]       slave_readdata;
  logic              slave_readdatavalid;
  logic [3:0]        stall_cycles;
  logic [ADDR_W-1:0] bd_addr;
  logic              bd_we;
  logic [31:0]       bd_wdata;
  logic [31:0]       bd_rdata;
  logic              err_oor;
  logic              err_proto;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;

  dnn_sdram_responder #(
    .ADDR_W  (ADDR_W),
    .READ_LAT(READ_LAT),
    .OOR_DATA(OOR)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .slave_address      (slave_address),
    .slave_read         (slave_read),
    .slave_write        (slave_write),
    .slave_writedata    (slave_writedata),
    .slave_waitrequest  (slave_waitrequest),
    .slave_readdata     (slave_readdata),
    .slave_readdatavalid(slave_readdatavalid),
    .stall_cycles       (stall_cycles),
    .bd_addr            (bd_addr),
    .bd_we              (bd_we),
    .bd_wdata           (bd_wdata),
    .bd_rdata           (bd_rdata),
    .err_oor            (err_oor),
    .err_proto          (err_proto),
    .rd_count           (rd_count),
    .wr_count           (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] model_mem [DEPTH];
  int          m_rd, m_wr;
  bit          m_oor, m_proto;
  exp_t        exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every read reply must land exactly READ_LAT cycles after its accept cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("rdv_pulse", 32'(slave_readdatavalid), 32'd1);
        chk("readdata", slave_readdata, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        chk("rdv_quiet", 32'(slave_readdatavalid), 32'd0);
      end
    end
  end

  // Called just after a falling edge; returns just after the falling edge
  // following the accept edge, with the request lines cleared.
  task automatic do_req(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_waits, input string tag);
    int waits;
    int t;
    logic [ADDR_W-1:0] idx;
    bit o;
    waits = 0;
    slave_address   = addr;
    slave_read      = rd;
    slave_write     = !rd;
    slave_writedata = wd;
    #1;
    while (slave_waitrequest !== 1'b0 && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    chk($sformatf("%s_waits", tag), 32'(waits), 32'(exp_waits));
    if (slave_waitrequest === 1'b0) begin
      t   = cyc;
      idx = addr[ADDR_W+1:2];
      o   = (addr[31:ADDR_W+2] != '0);
      if (rd) begin
        exp_q.push_back('{t + READ_LAT, o ? OOR : model_mem[idx]});
        m_rd++;
      end else begin
        m_wr++;
        if (!o) model_mem[idx] = wd;
      end
      if (o) m_oor = 1'b1;
    end
    @(negedge clk);
    slave_read  = 1'b0;
    slave_write = 1'b0;
  endtask

  task automatic bd_wr(input int a, input logic [31:0] d);
    bd_addr  = ADDR_W'(a);
    bd_wdata = d;
    bd_we    = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic bd_chk(input int a, input string tag);
    bd_addr = ADDR_W'(a);
    @(negedge clk);
    chk(tag, bd_rdata, model_mem[a]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    bit          rd;
    int          st;
    slave_address   = '0;
    slave_read      = 1'b0;
    slave_write     = 1'b0;
    slave_writedata = '0;
    stall_cycles    = 4'd0;
    bd_addr         = '0;
    bd_we           = 1'b0;
    bd_wdata        = '0;
    rst_n           = 1'b0;
    m_rd = 0; m_wr = 0; m_oor = 1'b0; m_proto = 1'b0;

    // Reset values
    idle(3);
    chk("rst_rdv", 32'(slave_readdatavalid), 32'd0);
    chk("rst_rdata", slave_readdata, 32'd0);
    chk("rst_bd_rdata", bd_rdata, 32'd0);
    chk("rst_err_oor", 32'(err_oor), 32'd0);
    chk("rst_err_proto", 32'(err_proto), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_wait", 32'(slave_waitrequest), 32'd1);
    rst_n = 1'b1;
    #1 chk("release_wait", 32'(slave_waitrequest), 32'd1);
    @(negedge clk);
    #1 chk("ready_wait", 32'(slave_waitrequest), 32'd0);
    mon_en = 1'b1;

    // Preload every word so random reads compare against defined data
    for (int i = 0; i < DEPTH; i++) bd_wr(i, (i < 4) ? 32'(i + 1) : $urandom);

    // Four back-to-back reads, no stall
    stall_cycles = 4'd0;
    for (int i = 0; i < 4; i++) do_req(1'b1, 32'(i * 4), 32'd0, 0, $sformatf("rd%0d", i));
    idle(READ_LAT + 2);
    chk("rd_count_4", 32'(rd_count), 32'd4);

    // Stalled write, then backdoor readback
    stall_cycles = 4'd3;
    do_req(1'b0, 32'h10, 32'hCAFEF00D, 3, "wr_stall3");
    stall_cycles = 4'd0;
    chk("wr_count_1", 32'(wr_count), 32'd1);
    bd_chk(4, "bd4_model");
    chk("bd4_const", bd_rdata, 32'hCAFEF00D);

    // Read right after write to the same word
    do_req(1'b0, 32'h20, 32'h55, 0, "wr55");
    do_req(1'b1, 32'h20, 32'd0, 0, "rd55");
    idle(READ_LAT + 2);

    // Out-of-range read and write
    do_req(1'b1, 32'h0001_0000, 32'd0, 0, "rd_oor");
    idle(READ_LAT + 2);
    chk("err_oor", 32'(err_oor), 32'd1);
    do_req(1'b0, 32'h0001_0000, 32'h1234_5678, 0, "wr_oor");
    chk("wr_count_oor", 32'(wr_count), 32'(m_wr));
    bd_chk(0, "bd0_model");
    chk("bd0_const", bd_rdata, 32'd1);

    // Read and write asserted together
    slave_address = 32'h8;
    slave_read    = 1'b1;
    slave_write   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("proto_wait%0d", i), 32'(slave_waitrequest), 32'd1);
      if (i > 0) chk($sformatf("proto_err%0d", i), 32'(err_proto), 32'd1);
      @(negedge clk);
    end
    slave_read  = 1'b0;
    slave_write = 1'b0;
    m_proto     = 1'b1;
    chk("proto_rd_count", 32'(rd_count), 32'(m_rd));
    chk("proto_wr_count", 32'(wr_count), 32'(m_wr));

    // Slave write beats a same-cycle backdoor write to the same word
    bd_addr  = ADDR_W'(16);
    bd_wdata = 32'hB0B0B0B0;
    bd_we    = 1'b1;
    do_req(1'b0, 32'h40, 32'hA5A5A5A5, 0, "collide");
    bd_we = 1'b0;
    bd_chk(16, "collide_model");
    chk("collide_const", bd_rdata, 32'hA5A5A5A5);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        bd_wr($urandom_range(0, DEPTH - 1), $urandom);
      end else begin
        st   = $urandom_range(0, 3);
        stall_cycles = 4'(st);
        addr = $urandom;
        addr[31:12] = '0;
        if ($urandom_range(0, 9) == 0) addr[31:12] = 20'($urandom_range(1, 20'hFFFFF));
        rd = 1'($urandom_range(0, 1));
        do_req(rd, addr, $urandom, st, $sformatf("rnd%0d", n));
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    stall_cycles = 4'd0;
    idle(READ_LAT + 2);
    chk("rnd_rd_count", 32'(rd_count), m_rd & 32'hFFFF);
    chk("rnd_wr_count", 32'(wr_count), m_wr & 32'hFFFF);
    chk("rnd_err_oor", 32'(err_oor), 32'(m_oor));
    chk("rnd_err_proto", 32'(err_proto), 32'(m_proto));
    chk("rnd_drain", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 8; i++) bd_chk($urandom_range(0, DEPTH - 1), $sformatf("rnd_bd%0d", i));

    // Reset while reads are in flight
    do_req(1'b1, 32'h0, 32'd0, 0, "pre_rst_rd0");
    slave_address = 32'h4;
    slave_read    = 1'b1;
    rst_n         = 1'b0;
    exp_q.delete();
    m_rd = 0; m_wr = 0; m_oor = 1'b0; m_proto = 1'b0;
    @(negedge clk);
    slave_read = 1'b0;
    rst_n      = 1'b1;
    #1 chk("mid_rst_wait", 32'(slave_waitrequest), 32'd1);
    chk("mid_rst_rd_count", 32'(rd_count), 32'd0);
    chk("mid_rst_wr_count", 32'(wr_count), 32'd0);
    chk("mid_rst_err_oor", 32'(err_oor), 32'd0);
    chk("mid_rst_err_proto", 32'(err_proto), 32'd0);
    @(negedge clk);
    #1 chk("mid_rst_ready", 32'(slave_waitrequest), 32'd0);
    idle(3);
    do_req(1'b1, 32'h0, 32'd0, 0, "post_rst_rd0");
    do_req(1'b1, 32'h4, 32'd0, 0, "post_rst_rd1");
    idle(READ_LAT + 2);
    chk("post_rst_rd_count", 32'(rd_count), 32'd2);
    chk("post_rst_drain", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dnn_sdram_responder.md
Name: dnn_sdram_responder

Overview:
Avalon-MM pipelined-read slave that answers the DNN master's SDRAM-facing port. It provides a word-addressed memory with a programmable waitrequest stall and a fixed read latency. It also has a backdoor port so benches and host logic can preload weights and activations and inspect results. It sits on the SDRAM side of the DNN master for simulation and for FPGA bring-up without external SDRAM.

Parameters:
ADDR_W, 10, word-index width; memory holds 2^ADDR_W 32-bit words.
READ_LAT, 2, cycles from read accept to readdatavalid; legal range 1..8.
OOR_DATA, 32'hDEADBEEF, readdata returned for out-of-range reads.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
slave_address  in  32  byte address; bits [1:0] ignored
slave_read  in  1  read request
slave_write  in  1  write request
slave_writedata  in  32  write data
slave_waitrequest  out  1  request not accepted this cycle
slave_readdata  out  32  read data, valid with readdatavalid
slave_readdatavalid  out  1  one-cycle pulse per accepted read
stall_cycles  in  4  waitrequest cycles imposed on each new request
bd_addr  in  ADDR_W  backdoor word index
bd_we  in  1  backdoor write strobe
bd_wdata  in  32  backdoor write data
bd_rdata  out  32  backdoor read data, registered, 1-cycle latency
err_oor  out  1  sticky: an out-of-range access was accepted
err_proto  out  1  sticky: read and write were asserted together
rd_count  out  16  accepted reads, wraps at 16'hFFFF -> 0
wr_count  out  16  accepted writes, wraps

Behaviour:
- Reset (rst_n low at posedge):
  - outputs: readdatavalid=0, readdata=0, bd_rdata=0, err_oor=0, err_proto=0, rd_count=0, wr_count=0.
  - the read pipeline is flushed, the stall counter is cleared, and ready_q is cleared.
  - memory contents are NOT cleared.
- ready_q is set on the first posedge after rst_n goes high. slave_waitrequest = 1 whenever ready_q=0, so waitrequest is high during reset and for the first cycle out of reset.
- Word index = slave_address[ADDR_W+1:2]. The access is out of range if slave_address[31:ADDR_W+2] != 0.
- Request = slave_read XOR slave_write.
- Both read and write high at once:
  - waitrequest=1 and nothing is accepted; the request is held off indefinitely.
  - err_proto sets on the next edge.
- Stall counter (sc), 4 bits:
  - Idle -> on a new request, sc loads 0 and waitrequest=1 while sc < stall_cycles; sc increments each cycle.
  - The request is accepted in the first cycle with sc == stall_cycles (stall_cycles=0: accepted in the cycle of assertion).
  - After accept, sc returns to idle.
  - A request dropped before accept (protocol violation) returns sc to idle with no side effects.
  - Back-to-back requests are each stalled independently.
  - waitrequest is combinational from the request, sc, and ready_q.
- Accepted write (cycle T): the memory word is updated at the T edge and wr_count increments. An out-of-range write is dropped and sets err_oor.
- Accepted read (cycle T):
  - readdatavalid=1 for exactly the cycle T+READ_LAT; rd_count increments at the T edge.
  - Reads complete in order. One read may be accepted per cycle, so up to READ_LAT reads are in flight.
  - Data reflects memory state after all writes accepted before T. A read accepted at T+1 after a write at T to the same word returns the new data.
  - An out-of-range read returns OOR_DATA and sets err_oor.
- readdata holds its last value when readdatavalid=0.
- Backdoor port:
  - bd_rdata = mem[bd_addr] sampled at the previous edge.
  - If bd_we and an accepted slave write hit the same word in the same cycle, the slave write wins.
  - Backdoor accesses never stall the slave port.
- Reset mid-operation: in-flight reads are discarded and no readdatavalid pulse is produced after the reset edge. Counters and error flags clear.

Test Plan:
- Backdoor preload mem[0..3]=1,2,3,4; stall_cycles=0, READ_LAT=2; read at byte addresses 0x0,0x4,0x8,0xC on consecutive cycles -> waitrequest low throughout; readdatavalid pulses at cycles T+2..T+5 with 1,2,3,4; rd_count=4.
- stall_cycles=3; single write of 0xCAFEF00D to addr 0x10 -> waitrequest high for exactly 3 cycles, accepted on the 4th; wr_count=1; bd_addr=4 then reads 0xCAFEF00D.
- Write 0x55 to 0x20 at T, read 0x20 at T+1 -> readdatavalid at T+1+READ_LAT with data 0x55.
- Read byte address 0x00010000 with ADDR_W=10 -> readdata=0xDEADBEEF and err_oor=1. Then write to the same address -> memory unchanged and wr_count increments.
- Assert read and write together for 5 cycles -> waitrequest held 1, no counter change, err_proto=1 after the first edge.
- Accept 2 reads, then assert rst_n=0 for 1 cycle before data returns -> no readdatavalid pulse; rd_count=0; waitrequest=1 for 1 cycle after release; previously preloaded memory is still readable.
